nn_pattern_driver: RTL
======================

Name: nn_pattern_driver

Overview:
Host-side initiator for the 16-input board classifier's start/rdy handshake. It buffers board patterns written by the host and issues them one at a time on data/start. It holds data stable for the whole classification, because the classifier re-samples data for every neuron. It captures each 2-bit result, keeps per-class tallies, and reports completion of a batch.

Parameters:
N, 16, pattern width (one bit per board cell)
DEPTH, 8, pattern buffer entries (power of 2)
TIMEOUT, 1023, max ena-qualified cycles from nn_start to nn_rdy

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  clock enable shared with classifier
wr_en  in  1  push wr_data into buffer
wr_data  in  N  board pattern
wr_exp  in  2  expected label (used only with NN_DRV_EXPECT_EN)
full  out  1  buffer full
buf_cnt  out  log2(DEPTH)+1  entries held
go  in  1  process all buffered patterns
busy  out  1  batch in progress
done  out  1  one-cycle pulse, batch finished
nn_data  out  N  to classifier data
nn_start  out  1  to classifier start
nn_res  in  2  classifier res[1:0]
nn_rdy  in  1  classifier rdy
res_valid  out  1  one-cycle pulse, result available
res_code  out  2  01=x, 00=o, 10=none, 11=timeout
res_pattern  out  N  pattern that produced res_code
cnt_x, cnt_o, cnt_none  out  8 each  saturating tallies
timeout_err  out  1  sticky
mismatch_cnt  out  8  saturating label mismatches

Behaviour:
- Single clock; rst is synchronous and active-high, takes priority over ena. All other registers update only when ena=1; ena=0 freezes everything and ignores wr_en/go.
- Reset values: all outputs 0, FSM IDLE, buffer empty. Reset mid-batch abandons the batch without a done pulse. The system resets the classifier with the same rst.
- Buffer is a FIFO. A push is accepted when wr_en=1 and not full; a push while full is dropped. Pushing is legal in any state, and a push and pop in the same cycle are both performed. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT, STORE, FIN.
  - IDLE: on go, clear cnt_x/cnt_o/cnt_none/mismatch_cnt and set busy=1. Go to LOAD if buf_cnt>0, else FIN. go outside IDLE is ignored.
  - LOAD: pop head into nn_data and res_pattern, clear the timeout counter, go to START.
  - START: nn_start=1 for exactly one ena-qualified cycle, then go to WAIT.
  - WAIT: nn_data is held. Increment the timeout counter each cycle.
    - nn_rdy=1: latch nn_res into res_code, go to STORE.
    - Counter reaches TIMEOUT without rdy: res_code=11, set timeout_err, go to STORE.
    - nn_rdy outside WAIT is ignored.
  - STORE: res_valid=1 for one cycle. Increment the tally matching res_code, saturating at 255; code 11 is not tallied. Then go to LOAD if buf_cnt>0, else FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Timing: from go, the first nn_start comes 2 cycles later. Back-to-back patterns have nn_start spaced by (rdy latency + 3) cycles. The classifier is idle the cycle it asserts rdy, so the next start is always legal.
- Patterns pushed during a batch are processed in the same batch if pushed before STORE samples buf_cnt.
- nn_data keeps the last pattern after the batch ends.

Optional Feature:
NN_DRV_EXPECT_EN: when defined, each buffer entry stores {wr_exp, wr_data}. In STORE, if res_code differs from the stored label (including 11), mismatch_cnt increments, saturating at 255. When undefined, the buffer is N bits wide, wr_exp is ignored and mismatch_cnt is tied to 0.

Test Plan:
- Reset then idle: all outputs 0; push 16'h8421 → buf_cnt=1, nn_start stays 0 without go.
- Push 16'hF000, 16'h000F; go; bench responder returns rdy 200 cycles after start with res=01 then 00 → two res_valid pulses, with res_pattern F000 and 000F in order, cnt_x=1, cnt_o=1, done pulse after the second STORE. nn_data is constant throughout each WAIT.
- Push 9 patterns with DEPTH=8 → full=1 after 8, ninth dropped, buf_cnt=8; batch yields 8 results.
- Responder never asserts rdy → res_code=11 exactly TIMEOUT cycles after nn_start, timeout_err=1, no tally change, FSM proceeds to the next pattern.
- ena toggled 1-0 every cycle during a batch → identical result sequence, with cycle counts doubled. Assert rst in the middle of WAIT → next cycle all outputs 0, no done pulse.
- With NN_DRV_EXPECT_EN: push pattern with wr_exp=01, responder returns 10 → mismatch_cnt=1, cnt_none=1.

Source files
------------

// File: rtl/nn_pattern_driver.sv
// nn_pattern_driver: buffers host board patterns and drives them one at a time
// into the 16-input classifier over start/rdy; optional label check via NN_DRV_EXPECT_EN.
module nn_pattern_driver #(
    parameter int N       = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   wr_en,
    input  logic [N-1:0]           wr_data,
    input  logic [1:0]             wr_exp,
    output logic                   full,
    output logic [$clog2(DEPTH):0] buf_cnt,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           nn_data,
    output logic                   nn_start,
    input  logic [1:0]             nn_res,
    input  logic                   nn_rdy,
    output logic                   res_valid,
    output logic [1:0]             res_code,
    output logic [N-1:0]           res_pattern,
    output logic [7:0]             cnt_x,
    output logic [7:0]             cnt_o,
    output logic [7:0]             cnt_none,
    output logic                   timeout_err,
    output logic [7:0]             mismatch_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef NN_DRV_EXPECT_EN
    localparam int EW = N + 2;
`else
    localparam int EW = N;
`endif

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [TW-1:0] tmo_t;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT, STORE, FIN
    } state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    cnt_t          count;
    logic          push;
    logic          pop;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    tmo_t          tcnt;

    assign full    = (count == cnt_t'(DEPTH));
    assign buf_cnt = count;
    assign push    = wr_en && !full;
    assign pop     = (state == LOAD);
    assign head    = mem[rd_ptr];

`ifdef NN_DRV_EXPECT_EN
    logic [1:0] exp_lbl;
    logic [7:0] mism;
    assign entry        = {wr_exp, wr_data};
    assign mismatch_cnt = mism;
`else
    logic unused_exp;
    assign entry        = wr_data;
    assign unused_exp   = ^wr_exp;
    assign mismatch_cnt = 8'd0;
`endif

    // FIFO pointers and occupancy; push and pop in one cycle both take effect
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ena) begin
            if (push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: ;
            endcase
        end
    end

    // Pattern storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (!rst && ena && push)
            mem[wr_ptr] <= entry;
    end

    // Batch sequencer with registered handshake, result and tally outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            nn_data     <= '0;
            nn_start    <= 1'b0;
            res_valid   <= 1'b0;
            res_code    <= 2'b00;
            res_pattern <= '0;
            cnt_x       <= 8'd0;
            cnt_o       <= 8'd0;
            cnt_none    <= 8'd0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
`ifdef NN_DRV_EXPECT_EN
            exp_lbl     <= 2'b00;
            mism        <= 8'd0;
`endif
        end else if (ena) begin
            done      <= 1'b0;
            nn_start  <= 1'b0;
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        cnt_x    <= 8'd0;
                        cnt_o    <= 8'd0;
                        cnt_none <= 8'd0;
`ifdef NN_DRV_EXPECT_EN
                        mism     <= 8'd0;
`endif
                        if (count != '0) begin
                            busy  <= 1'b1;
                            state <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                LOAD: begin
                    nn_data     <= head[N-1:0];
                    res_pattern <= head[N-1:0];
`ifdef NN_DRV_EXPECT_EN
                    exp_lbl     <= head[N+1:N];
`endif
                    tcnt        <= '0;
                    nn_start    <= 1'b1;
                    state       <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // tcnt counts WAIT cycles; the last one is TIMEOUT
                    // cycles after nn_start and still honours rdy
                    if (nn_rdy) begin
                        res_code  <= nn_res;
                        res_valid <= 1'b1;
                        state     <= STORE;
                    end else if (tcnt == tmo_t'(TIMEOUT - 1)) begin
                        res_code    <= 2'b11;
                        timeout_err <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= STORE;
                    end else begin
                        tcnt <= tcnt + tmo_t'(1);
                    end
                end
                STORE: begin
                    case (res_code)
                        2'b01: if (cnt_x != 8'hFF) cnt_x <= cnt_x + 8'd1;
                        2'b00: if (cnt_o != 8'hFF) cnt_o <= cnt_o + 8'd1;
                        2'b10: if (cnt_none != 8'hFF) cnt_none <= cnt_none + 8'd1;
                        default: ;
                    endcase
`ifdef NN_DRV_EXPECT_EN
                    if (res_code != exp_lbl && mism != 8'hFF)
                        mism <= mism + 8'd1;
`endif
                    if (count != '0) begin
                        state <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
